srl_window_cnt: RTL and testbench
=================================

// Module: srl_window_cnt
// PURPOSE
//  Tracks pulses in flight through a fixed-length window. DIN is delayed DEPTH enabled cycles to DOUT.
//  An up/down counter holds the number of DIN pulses that have entered the window but not yet left it.
//  Used in trigger matching to detect overlapping match windows: OVERLAP = counter MSB.
//  Composes the shift-register delay (srl_nx1 role) with the up/down loadable counter (udl_cnt role).
// PARAMETERS
//  DEPTH  16  delay-line length in enabled cycles, 1..512
//  WIDTH  2   counter width in bits, >=1
//  TMR    0   1 = triplicate counter registers with a bitwise 2-of-3 majority vote on Q
// PORTS
//  CLK      in   1      single clock, all logic on rising edge
//  RST      in   1      synchronous, active-low reset (0 = reset)
//  CE       in   1      clock enable for delay line and counter
//  DIN      in   1      pulse entering window
//  L        in   1      synchronous counter load
//  D        in   WIDTH  counter load value
//  DOUT     out  1      DIN delayed DEPTH enabled cycles (window-exit edge)
//  Q        out  WIDTH  count of pulses currently in window (registered)
//  OVERLAP  out  1      Q[WIDTH-1]
// BEHAVIOUR
//  Reset (RST=0 at rising edge): all delay stages clear, so DOUT=0; Q=0; OVERLAP=0.
//  Reset takes priority over L and CE. Reset mid-run discards every pulse in flight.
//  Delay line:
//   - Shifts only when CE=1; holds when CE=0.
//   - With CE held at 1: DOUT(n) = DIN(n-DEPTH).
//   - DOUT is the last stage register, with no extra output register.
//  Counter (priority RST > L > count):
//   - L=1: Q <= D, regardless of CE.
//   - Otherwise, if CE=1 and DIN^DOUT:
//     - DIN=1: Q <= Q+1.
//     - DOUT=1: Q <= Q-1.
//   - DIN=DOUT=1: hold (enter and exit cancel).
//   - CE=0 or DIN=DOUT=0: hold.
//   - Arithmetic is modulo 2^WIDTH: overflow at all-ones wraps to 0; underflow at 0 wraps to all-ones.
//     There is no saturation.
//   - Count inputs (DIN, DOUT) are sampled in the same cycle, so the count changes one cycle after the pulse edge.
//  TMR=1:
//   - Three counter copies are updated identically.
//   - Q is the bitwise majority of the copies.
//   - Each copy's next state is computed from the voted Q, which scrubs single upsets.
//  OVERLAP is combinational from Q: no added latency.
// STRUCTURE
//  Shared package: none required. WIDTH/DEPTH stay module parameters; a majority-vote function may go in the common utility package.
//  Natural sub-module: udl_counter (WIDTH, TMR; ports CLK, RST, CE, L, UP, D, Q), instantiated with CE=CE&(DIN^DOUT), UP=DIN.
//  The delay line is inline: a DEPTH-bit shift register with synchronous clear.
// TESTING
//  1. Single pulse: DEPTH=16, CE=1, DIN=1 for 1 cycle at t0.
//     -> DOUT=1 exactly at t0+16.
//     -> Q=1 from t0+1 through t0+16; Q=0 from t0+17.
//  2. Overlap: two pulses 5 cycles apart.
//     -> Q=2 and OVERLAP=1 from the 2nd pulse +1 until the 1st exits.
//     -> Q falls 2->1->0 at the exits.
//  3. Wrap: WIDTH=2, four pulses with no exits.
//     -> Q steps 1,2,3,0.
//     -> L=1,D=0 then a DOUT-only exit -> Q=3.
//  4. Simultaneous: DIN=1 in the same cycle DOUT=1 -> Q unchanged.
//     CE=0 for 3 cycles mid-window -> DOUT arrival slips 3 cycles and Q is frozen.
//  5. Reset mid-operation: 3 pulses in flight, RST=0 one cycle.
//     -> Q=0, DOUT stays 0 for the next DEPTH cycles.
//     -> L=1 together with RST=0 -> Q=0.
//  6. TMR=1: force one counter copy to a wrong value.
//     -> Q is still correct, and the copy is rewritten on the next counting or load cycle.

Source files
------------

// File: rtl/srl_window_cnt_pkg.sv
// srl_window_cnt_pkg: shared defaults and the bitwise majority vote for the pulse-window counter
package srl_window_cnt_pkg;
   localparam int DEPTH_DEF = 16;
   localparam int WIDTH_DEF = 2;
   function automatic logic maj3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction
endpackage

// File: rtl/srl_window_cnt_counter.sv
// srl_window_cnt_counter: loadable up/down counter, optionally triplicated with a majority-voted output
module srl_window_cnt_counter
   import srl_window_cnt_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int TMR   = 0
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             ce_i,
   input  logic             l_i,
   input  logic             up_i,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);
   logic             en;
   logic [WIDTH-1:0] cnt_d;
   // next count comes from the visible (voted) value, so a damaged copy is repaired on its next write
   always_comb begin
      en    = l_i | ce_i;
      cnt_d = l_i ? d_i : (up_i ? q_o + 1'b1 : q_o - 1'b1);
   end
   if (TMR != 0) begin : g_tmr
      logic [WIDTH-1:0] c0_q, c1_q, c2_q;
      // three identical copies share one next-state value
      always_ff @(posedge clk_i) begin
         if (!rst_ni) begin
            c0_q <= '0;
            c1_q <= '0;
            c2_q <= '0;
         end else if (en) begin
            c0_q <= cnt_d;
            c1_q <= cnt_d;
            c2_q <= cnt_d;
         end
      end
      for (genvar i = 0; i < WIDTH; i++) begin : g_vote
         assign q_o[i] = maj3(c0_q[i], c1_q[i], c2_q[i]);
      end
   end else begin : g_single
      logic [WIDTH-1:0] cnt_q;
      // single counter register
      always_ff @(posedge clk_i) begin
         if (!rst_ni) cnt_q <= '0;
         else if (en) cnt_q <= cnt_d;
      end
      assign q_o = cnt_q;
   end
endmodule

// File: rtl/srl_window_cnt.sv
// srl_window_cnt: counts pulses in flight through a DEPTH-cycle delay window; overlap flag is the count MSB
module srl_window_cnt
   import srl_window_cnt_pkg::*;
#(
   parameter int DEPTH = DEPTH_DEF,
   parameter int WIDTH = WIDTH_DEF,
   parameter int TMR   = 0
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             ce_i,
   input  logic             din_i,
   input  logic             l_i,
   input  logic [WIDTH-1:0] d_i,
   output logic             dout_o,
   output logic [WIDTH-1:0] q_o,
   output logic             overlap_o
);
   logic [DEPTH-1:0] sr_q, sr_d;
   // shift DIN into the window on enabled cycles; truncation keeps this valid down to DEPTH=1
   always_comb sr_d = ce_i ? DEPTH'({sr_q, din_i}) : sr_q;
   // delay line with synchronous clear, so a reset drops every pulse in flight
   always_ff @(posedge clk_i) sr_q <= !rst_ni ? '0 : sr_d;
   assign dout_o    = sr_q[DEPTH-1];
   assign overlap_o = q_o[WIDTH-1];
   srl_window_cnt_counter #(.WIDTH(WIDTH), .TMR(TMR)) u_cnt (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .ce_i   (ce_i & (din_i ^ dout_o)),
      .l_i    (l_i),
      .up_i   (din_i),
      .d_i    (d_i),
      .q_o    (q_o)
   );
endmodule

// File: tb/tb_srl_window_cnt.sv
// tb_srl_window_cnt: directed table-driven checks of the pulse-window counter, plain and triplicated
module tb_srl_window_cnt;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0, ce = 1'b1, din = 1'b0, l = 1'b0;
   logic [1:0] d = 2'd0;
   logic       dout_s, ovl_s, dout_t, ovl_t;
   logic [1:0] q_s, q_t;
   int         n_chk = 0, n_fail = 0;

   typedef struct {
      int         gap;
      logic       rst_n, ce, din, l;
      logic [1:0] d;
      logic       exp_dout;
      logic [1:0] exp_q;
      string      name;
   } vec_t;
   vec_t vecs[$];

   srl_window_cnt #(.DEPTH(16), .WIDTH(2), .TMR(0)) dut_s (
      .clk_i(clk), .rst_ni(rst_n), .ce_i(ce), .din_i(din), .l_i(l), .d_i(d),
      .dout_o(dout_s), .q_o(q_s), .overlap_o(ovl_s));
   srl_window_cnt #(.DEPTH(16), .WIDTH(2), .TMR(1)) dut_t (
      .clk_i(clk), .rst_ni(rst_n), .ce_i(ce), .din_i(din), .l_i(l), .d_i(d),
      .dout_o(dout_t), .q_o(q_t), .overlap_o(ovl_t));

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      rst_n = 1'b1; ce = 1'b1; din = 1'b0; l = 1'b0; d = 2'd0;
   endtask

   task automatic chk(input string nm, input int act, input int exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic add(input int gap, input logic r, input logic c, input logic i, input logic ld,
                      input logic [1:0] dv, input logic ed, input logic [1:0] eq, input string nm);
      vec_t v;
      v.gap = gap; v.rst_n = r; v.ce = c; v.din = i; v.l = ld; v.d = dv;
      v.exp_dout = ed; v.exp_q = eq; v.name = nm;
      vecs.push_back(v);
   endtask

   task automatic chk_all(input string nm, input logic ed, input logic [1:0] eq);
      chk({nm, "_dout"}, int'(dout_s), int'(ed));
      chk({nm, "_q"}, int'(q_s), int'(eq));
      chk({nm, "_ovl"}, int'(ovl_s), int'(eq[1]));
      chk({nm, "_dout_tmr"}, int'(dout_t), int'(ed));
      chk({nm, "_q_tmr"}, int'(q_t), int'(eq));
   endtask

   initial begin
      //   gap rst ce din l  d  dout q
      add(0,  0, 1, 0, 0, 0, 0, 0, "reset");
      add(0,  1, 1, 1, 0, 0, 0, 1, "s1_enter");
      add(13, 1, 1, 0, 0, 0, 0, 1, "s1_t15");
      add(0,  1, 1, 0, 0, 0, 1, 1, "s1_exit");
      add(0,  1, 1, 0, 0, 0, 0, 0, "s1_after");
      add(0,  1, 1, 1, 0, 0, 0, 1, "s2_p1");
      add(4,  1, 1, 1, 0, 0, 0, 2, "s2_p2");
      add(9,  1, 1, 0, 0, 0, 1, 2, "s2_exit1");
      add(0,  1, 1, 0, 0, 0, 0, 1, "s2_dec1");
      add(3,  1, 1, 0, 0, 0, 1, 1, "s2_exit2");
      add(0,  1, 1, 0, 0, 0, 0, 0, "s2_dec2");
      add(0,  1, 1, 1, 0, 0, 0, 1, "s3_up1");
      add(0,  1, 1, 1, 0, 0, 0, 2, "s3_up2");
      add(0,  1, 1, 1, 0, 0, 0, 3, "s3_up3");
      add(0,  1, 1, 1, 0, 0, 0, 0, "s3_wrap");
      add(0,  1, 1, 0, 1, 0, 0, 0, "s3_load0");
      add(10, 1, 1, 0, 0, 0, 1, 0, "s3_exit_vis");
      add(0,  1, 1, 0, 0, 0, 1, 3, "s3_underflow");
      add(0,  1, 1, 0, 0, 0, 1, 2, "s3_dn2");
      add(0,  1, 1, 0, 0, 0, 1, 1, "s3_dn1");
      add(0,  1, 1, 0, 0, 0, 0, 0, "s3_dn0");
      add(0,  1, 1, 1, 0, 0, 0, 1, "s4_enter");
      add(14, 1, 1, 0, 0, 0, 1, 1, "s4_exit_vis");
      add(0,  1, 1, 1, 0, 0, 0, 1, "s4_simul");
      add(2,  1, 0, 1, 0, 0, 0, 1, "s4_freeze0");
      add(0,  1, 0, 0, 0, 0, 0, 1, "s4_freeze1");
      add(0,  1, 0, 0, 0, 0, 0, 1, "s4_freeze2");
      add(11, 1, 1, 0, 0, 0, 0, 1, "s4_pre_slip");
      add(0,  1, 1, 0, 0, 0, 1, 1, "s4_slip_vis");
      add(0,  1, 1, 0, 0, 0, 0, 0, "s4_dec");
      add(0,  1, 0, 0, 1, 2, 0, 2, "ld_ce0");
      add(0,  1, 0, 0, 1, 0, 0, 0, "ld_zero");

      for (int k = 0; k < vecs.size(); k++) begin
         repeat (vecs[k].gap) begin
            idle();
            step();
         end
         rst_n = vecs[k].rst_n; ce = vecs[k].ce; din = vecs[k].din; l = vecs[k].l; d = vecs[k].d;
         step();
         chk_all($sformatf("%s[%0d]", vecs[k].name, k), vecs[k].exp_dout, vecs[k].exp_q);
      end

      // reset mid-operation: three pulses in flight are discarded
      for (int k = 1; k <= 3; k++) begin
         idle(); din = 1'b1;
         step();
         chk_all($sformatf("s5_fill%0d", k), 1'b0, 2'(k));
      end
      rst_n = 1'b0; din = 1'b1;
      step();
      chk_all("s5_reset", 1'b0, 2'd0);
      for (int k = 0; k < 16; k++) begin
         idle();
         step();
         chk($sformatf("s5_quiet%0d_dout", k), int'(dout_s), 0);
         chk($sformatf("s5_quiet%0d_q", k), int'(q_s), 0);
      end
      idle(); l = 1'b1; d = 2'd2;
      step();
      chk_all("s5_load2", 1'b0, 2'd2);
      rst_n = 1'b0; l = 1'b1; d = 2'd3;
      step();
      chk_all("s5_rst_vs_load", 1'b0, 2'd0);

      // single-copy upsets in the triplicated counter
      idle(); ce = 1'b0; l = 1'b1; d = 2'd1;
      step();
      chk("tmr_load1_q", int'(q_t), 1);
      l = 1'b0;
      force dut_t.u_cnt.g_tmr.c1_q = 2'd3;
      #1;
      chk("tmr_upset_q", int'(q_t), 1);
      release dut_t.u_cnt.g_tmr.c1_q;
      step();
      chk("tmr_hold_q", int'(q_t), 1);
      ce = 1'b1; din = 1'b1;
      step();
      chk("tmr_count_q", int'(q_t), 2);
      chk("tmr_scrub_c1", int'(dut_t.u_cnt.g_tmr.c1_q), 2);
      ce = 1'b0; din = 1'b0;
      force dut_t.u_cnt.g_tmr.c0_q = 2'd0;
      #1;
      chk("tmr_upset0_q", int'(q_t), 2);
      release dut_t.u_cnt.g_tmr.c0_q;
      l = 1'b1; d = 2'd3;
      step();
      chk("tmr_load3_q", int'(q_t), 3);
      chk("tmr_scrub_c0", int'(dut_t.u_cnt.g_tmr.c0_q), 3);
      chk("tmr_ovl", int'(ovl_t), 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
